uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one uart_tx byte stream.
// A granted requester keeps the transmitter until its last byte or an idle timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_grant,
  output logic [DATA_W-1:0]       o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int  IDX_W      = $clog2(N_REQ);
  localparam int  CNT_W      = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam bit  TIMEOUT_EN = (IDLE_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_PASS} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] idle_cnt;

  logic             own_valid;
  logic             own_last;
  logic             own_xfer;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick;
  logic             pick_found;

  always_comb begin
    own_valid = i_req_valid[owner];
    own_last  = i_req_last[owner];
    own_xfer  = own_valid & i_tx_ready;
    next_ptr  = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
  end

  // Scan offsets from the far end so the valid requester closest to ptr wins.
  always_comb begin
    pick       = ptr;
    pick_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[(int'(ptr) + i) % N_REQ]) begin
        pick       = IDX_W'((int'(ptr) + i) % N_REQ);
        pick_found = 1'b1;
      end
    end
  end

  // Owner's byte stream is forwarded combinationally so a byte moves in the grant cycle.
  always_comb begin
    // NOTE: every output gets a default before the conditional so no latch is inferred.
    o_req_ready = '0;
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    if (state == S_PASS) begin
      o_req_ready[owner] = i_tx_ready;
      o_tx_valid         = own_valid;
      o_tx_data          = i_req_data[int'(owner)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      owner     <= '0;
      ptr       <= '0;
      idle_cnt  <= '0;
      o_grant   <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          idle_cnt <= '0;
          if (pick_found) begin
            owner   <= pick;
            o_grant <= N_REQ'(1) << pick;
            o_busy  <= 1'b1;
            state   <= S_PASS;
          end
        end
        S_PASS: begin
          if (own_xfer) begin
            idle_cnt <= '0;
            if (own_last) begin
              ptr     <= next_ptr;
              o_grant <= '0;
              o_busy  <= 1'b0;
              state   <= S_IDLE;
            end
          end else if (!own_valid) begin
            if (TIMEOUT_EN && idle_cnt == CNT_LIMIT) begin
              ptr       <= next_ptr;
              idle_cnt  <= '0;
              o_grant   <= '0;
              o_busy    <= 1'b0;
              o_timeout <= 1'b1;
              state     <= S_IDLE;
            end else if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            // Owner is waiting on a busy transmitter, which is not idleness.
            idle_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester expected byte queues plus a
// cycle-level reference model of ownership, pointer and idle timeout.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  grant;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .IDLE_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_data(req_data), .i_req_valid(req_valid),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_grant(grant), .o_tx_data(tx_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_busy(busy), .o_timeout(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  byte_t      drive_q[N][$];
  logic [7:0] exp_q[N][$];
  int         xfer_log[$];
  int         pause_cnt[N];
  bit         pause_en = 1'b0;
  int         tx_mode = 2;   // 0: uart-like random busy, 1: stuck low, 2: always ready
  int         tx_busy = 0;
  int         dut_timeouts = 0;

  // Reference model: owner index (-1 = none), rotation start, consecutive idle cycles.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_idle  = 0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_outputs();
    logic [N-1:0] g;
    logic [N-1:0] r;
    logic         v;
    logic [7:0]   d;
    g = '0; r = '0; v = 1'b0; d = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      r[m_owner] = tx_ready;
      v          = req_valid[m_owner];
      d          = req_data[m_owner*DW +: DW];
    end
    return 64'({g, r, v, d, (m_owner >= 0), m_to});
  endfunction

  task automatic model_edge(output logic [N-1:0] xfer);
    int  w;
    bit  found;
    xfer = '0;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && req_valid[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          m_idle  = 0;
          found   = 1'b1;
        end
      end
    end else begin
      w = m_owner;
      if (req_valid[w] && tx_ready) begin
        xfer[w] = 1'b1;
        m_idle  = 0;
        if (req_last[w]) begin
          m_owner = -1;
          m_ptr   = (w + 1) % N;
        end
      end else if (!req_valid[w]) begin
        m_idle++;
        if (m_idle >= TO) begin
          m_owner = -1;
          m_ptr   = (w + 1) % N;
          m_idle  = 0;
          m_to    = 1'b1;
        end
      end else begin
        m_idle = 0;
      end
    end
  endtask

  task automatic drive_reqs(input logic [N-1:0] xfer);
    for (int k = 0; k < N; k++) begin
      if (xfer[k]) begin
        drive_q[k].delete(0);
        req_valid[k] = 1'b0;
      end
      if (!req_valid[k]) begin
        if (pause_cnt[k] > 0) begin
          pause_cnt[k]--;
        end else if (drive_q[k].size() > 0) begin
          if (pause_en && $urandom_range(0, 7) == 0) begin
            pause_cnt[k] = $urandom_range(1, 20);
          end else begin
            req_valid[k]            = 1'b1;
            req_data[k*DW +: DW]    = drive_q[k][0].data;
            req_last[k]             = drive_q[k][0].last;
          end
        end
      end
    end
  endtask

  task automatic drive_tx(input bit any_xfer);
    case (tx_mode)
      1: tx_ready = 1'b0;
      2: tx_ready = 1'b1;
      default: begin
        if (any_xfer) tx_busy = $urandom_range(0, 3);
        else if (tx_busy > 0) tx_busy--;
        tx_ready = (tx_busy == 0);
      end
    endcase
  endtask

  // One clock: compare at the falling edge, advance model and stimulus just after the rising edge.
  task automatic step();
    logic [N-1:0] xfer;
    @(negedge clk);
    check("cycle {grant,ready,tx_valid,tx_data,busy,timeout}",
          64'({grant, req_ready, tx_valid, tx_data, busy, timeout}), model_outputs());
    if (timeout === 1'b1) dut_timeouts++;
    @(posedge clk);
    model_edge(xfer);
    #1;
    drive_reqs(xfer);
    drive_tx(|xfer);
  endtask

  task automatic add_byte(input int k, input logic [7:0] d, input logic last);
    byte_t b;
    b.data = d;
    b.last = last;
    drive_q[k].push_back(b);
    exp_q[k].push_back(d);
  endtask

  task automatic add_pkt(input int k, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) add_byte(k, base + 8'(i), i == len - 1);
  endtask

  function automatic bit pending();
    bit p;
    p = (req_valid != '0);
    for (int k = 0; k < N; k++) if (drive_q[k].size() > 0) p = 1'b1;
    return p;
  endfunction

  function automatic int exp_left();
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += exp_q[k].size();
    return s;
  endfunction

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((pending() || m_owner >= 0) && n < budget) begin
      step();
      n++;
    end
    check({name, " finished within cycle budget"}, 64'(pending() || m_owner >= 0), 64'(0));
    step();
    check({name, " all expected bytes delivered"}, 64'(exp_left()), 64'(0));
  endtask

  task automatic check_log(input string name, input int exp[]);
    check({name, " transfer count"}, 64'(xfer_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < xfer_log.size(); i++)
      check($sformatf("%s transfer %0d requester", name, i), 64'(xfer_log[i]), 64'(exp[i]));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_busy   = 0;
    tx_ready  = (tx_mode != 1);
    for (int k = 0; k < N; k++) begin
      drive_q[k].delete();
      exp_q[k].delete();
      pause_cnt[k] = 0;
    end
    xfer_log.delete();
    dut_timeouts = 0;
    m_owner = -1; m_ptr = 0; m_idle = 0; m_to = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 64'({grant, req_ready, tx_valid, tx_data, busy, timeout}), 64'(0));
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted byte is matched against the owner's expected queue.
  always @(negedge clk) begin : monitor
    int k;
    if (rst_n && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      k = -1;
      for (int i = 0; i < N; i++) if (grant === (N'(1) << i)) k = i;
      check("transfer under one-hot grant", 64'(k >= 0), 64'(1));
      if (k >= 0) begin
        check($sformatf("req%0d has a byte outstanding", k), 64'(exp_q[k].size() > 0), 64'(1));
        if (exp_q[k].size() > 0) begin
          check($sformatf("req%0d byte", k), 64'(tx_data), 64'(exp_q[k].pop_front()));
          xfer_log.push_back(k);
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    for (int k = 0; k < N; k++) pause_cnt[k] = 0;

    // Single packet from requester 0.
    tx_mode = 0;
    do_reset();
    add_pkt(0, 3, 8'h41);
    drive_reqs('0);
    step();
    check("t1 grant one cycle after valid", 64'(grant), 64'(4'b0001));
    drain(200, "t1");
    check("t1 grant cleared", 64'(grant), 64'(0));
    check_log("t1", '{0, 0, 0});

    // Requesters 0 and 2 alternate packets.
    do_reset();
    add_pkt(0, 2, 8'h10); add_pkt(2, 2, 8'h20);
    add_pkt(0, 2, 8'h30); add_pkt(2, 2, 8'h40);
    drive_reqs('0);
    drain(400, "t2");
    check_log("t2", '{0, 0, 2, 2, 0, 0, 2, 2});

    // Requester 3 waits for requester 1's packet to complete.
    do_reset();
    add_pkt(1, 4, 8'h50);
    drive_reqs('0);
    step();
    add_pkt(3, 2, 8'h60);
    drive_reqs('0);
    for (int n = 0; n < 200 && drive_q[1].size() > 0; n++) step();
    step();
    check("t3 grant moves to requester 3", 64'(grant), 64'(4'b1000));
    drain(200, "t3");
    check_log("t3", '{1, 1, 1, 1, 3, 3});

    // Owner goes quiet after a non-last byte: forced release, requester 1 follows.
    tx_mode = 2;
    do_reset();
    add_byte(0, 8'h55, 1'b0);
    add_pkt(1, 1, 8'h66);
    drive_reqs('0);
    step();
    step();
    check("t4 first byte taken", 64'(exp_q[0].size()), 64'(0));
    repeat (16) step();
    check("t4 no timeout before 16 idle cycles", 64'(dut_timeouts), 64'(0));
    step();
    check("t4 timeout pulse", 64'(dut_timeouts), 64'(1));
    check("t4 requester 1 granted next", 64'(grant), 64'(4'b0010));
    drain(100, "t4");

    // Transmitter busy for a long time: waiting with valid high is not idleness.
    tx_mode = 1;
    do_reset();
    add_pkt(2, 1, 8'h77);
    drive_reqs('0);
    repeat (500) step();
    check("t5 no timeout while tx busy", 64'(dut_timeouts), 64'(0));
    check("t5 grant held", 64'(grant), 64'(4'b0100));
    check("t5 byte still pending", 64'(exp_q[2].size()), 64'(1));
    tx_mode = 2;
    tx_ready = 1'b1;
    drain(50, "t5");

    // Reset in the middle of a packet with the pointer away from 0.
    add_pkt(3, 3, 8'h80);
    drive_reqs('0);
    step();
    step();
    check("t6 owned before reset", 64'(grant), 64'(4'b1000));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async clear", 64'({grant, tx_valid, req_ready}), 64'(0));
    do_reset();
    add_pkt(3, 1, 8'h90);
    add_pkt(0, 1, 8'hA0);
    drive_reqs('0);
    step();
    check("t6 pointer back at 0", 64'(grant), 64'(4'b0001));
    drain(100, "t6");

    // Randomized traffic with requester pauses and a bursty transmitter.
    tx_mode = 0;
    do_reset();
    pause_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0)
        add_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), 8'($urandom));
      step();
    end
    drain(5000, "random");
    pause_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
